conv3d_loop_scheduler: RTL and testbench

CONV3D_LOOP_SCHEDULER -- requirements
Module: conv3d_loop_scheduler

---
 rtl/conv3d_loop_scheduler_if.sv | 54 +++++
 rtl/conv3d_loop_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv3d_loop_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/conv3d_loop_scheduler_if.sv
// -----------------------------------------------------------------------------
// conv3d_loop_scheduler_if
// Beat bus between the 3-D convolution loop scheduler and the MAC datapath.
//
// Parameters
//   DIM_W      width of every loop index (must match the scheduler's DIM_W)
//
// Signals
//   mac_valid  scheduler -> datapath  index tuple valid this cycle
//   mac_ready  datapath -> scheduler  datapath accepts the tuple this cycle
//   idx_*      scheduler -> datapath  current loop indices
//   in_d/h/w   scheduler -> datapath  input coordinates (DIM_W+1 bits)
//   acc_first  scheduler -> datapath  first term of an output-point accumulation
//   acc_last   scheduler -> datapath  last term of an output-point accumulation
//
// Modports
//   master     scheduler side
//   slave      datapath side
// -----------------------------------------------------------------------------
interface conv3d_loop_scheduler_if #(
   parameter int DIM_W = 8
);
   logic             mac_valid;
   logic             mac_ready;
   logic [DIM_W-1:0] idx_oc;
   logic [DIM_W-1:0] idx_od;
   logic [DIM_W-1:0] idx_oh;
   logic [DIM_W-1:0] idx_ow;
   logic [DIM_W-1:0] idx_ic;
   logic [DIM_W-1:0] idx_kd;
   logic [DIM_W-1:0] idx_kh;
   logic [DIM_W-1:0] idx_kw;
   logic [DIM_W:0]   in_d;
   logic [DIM_W:0]   in_h;
   logic [DIM_W:0]   in_w;
   logic             acc_first;
   logic             acc_last;

   modport master (
      output mac_valid,
      input  mac_ready,
      output idx_oc, idx_od, idx_oh, idx_ow, idx_ic, idx_kd, idx_kh, idx_kw,
      output in_d, in_h, in_w,
      output acc_first, acc_last
   );

   modport slave (
      input  mac_valid,
      output mac_ready,
      input  idx_oc, idx_od, idx_oh, idx_ow, idx_ic, idx_kd, idx_kh, idx_kw,
      input  in_d, in_h, in_w,
      input  acc_first, acc_last
   );
endinterface

// File: rtl/conv3d_loop_scheduler.sv
// -----------------------------------------------------------------------------
// conv3d_loop_scheduler
// Walks the eight nested loops of a stride-1, unpadded 3-D convolution
// (oc, od, oh, ow, ic, kd, kh, kw; kw innermost) and presents one index tuple
// per beat to a MAC datapath over a valid/ready handshake.
//
// Parameters
//   DIM_W   width of every configuration dimension and loop index
//   CNT_W   width of the stall counter (only used with CONV3D_SCHED_PERF_EN)
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pass request, honoured only in IDLE
//   cfg_oc..cfg_k  out-channels, output depth/height/width, in-channels,
//                  cubic kernel size; latched when start is accepted
//   mac            beat bus (master modport): mac_valid/mac_ready, indices,
//                  input coordinates, acc_first/acc_last
//   busy           high while tuples are being issued
//   done           one-cycle pulse when a pass finishes
//   stall_cnt      cycles with mac_valid && !mac_ready in the current pass,
//                  saturating; present only when CONV3D_SCHED_PERF_EN is defined
//
// Build option
//   CONV3D_SCHED_PERF_EN   adds the stall_cnt performance counter
// -----------------------------------------------------------------------------
module conv3d_loop_scheduler #(
   parameter int DIM_W = 8,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DIM_W-1:0]         cfg_oc,
   input  logic [DIM_W-1:0]         cfg_od,
   input  logic [DIM_W-1:0]         cfg_oh,
   input  logic [DIM_W-1:0]         cfg_ow,
   input  logic [DIM_W-1:0]         cfg_ic,
   input  logic [DIM_W-1:0]         cfg_k,
   conv3d_loop_scheduler_if.master  mac,
   output logic                     busy,
   output logic                     done
`ifdef CONV3D_SCHED_PERF_EN
   ,
   output logic [CNT_W-1:0]         stall_cnt
`endif
);

   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t state;

   // Latched configuration
   logic [DIM_W-1:0] oc_r, od_r, oh_r, ow_r, ic_r, k_r;

   // Per-loop terminal values (cfg - 1)
   logic [DIM_W-1:0] oc_m, od_m, oh_m, ow_m, ic_m, k_m;

   assign oc_m = oc_r - ONE;
   assign od_m = od_r - ONE;
   assign oh_m = oh_r - ONE;
   assign ow_m = ow_r - ONE;
   assign ic_m = ic_r - ONE;
   assign k_m  = k_r  - ONE;

   // Carry chain: each loop advances only when every inner loop wraps.
   logic c_kh, c_kd, c_ic, c_ow, c_oh, c_od, c_oc, last_all;

   assign c_kh     = (mac.idx_kw == k_m);
   assign c_kd     = c_kh & (mac.idx_kh == k_m);
   assign c_ic     = c_kd & (mac.idx_kd == k_m);
   assign c_ow     = c_ic & (mac.idx_ic == ic_m);
   assign c_oh     = c_ow & (mac.idx_ow == ow_m);
   assign c_od     = c_oh & (mac.idx_oh == oh_m);
   assign c_oc     = c_od & (mac.idx_od == od_m);
   assign last_all = c_oc & (mac.idx_oc == oc_m);

   function automatic logic [DIM_W-1:0] step_idx(
      input logic [DIM_W-1:0] idx,
      input logic [DIM_W-1:0] max_v,
      input logic             adv
   );
      if (!adv)
         return idx;
      return (idx == max_v) ? '0 : idx + ONE;
   endfunction

   logic [DIM_W-1:0] nxt_oc, nxt_od, nxt_oh, nxt_ow, nxt_ic, nxt_kd, nxt_kh, nxt_kw;
   logic [DIM_W:0]   nxt_in_d, nxt_in_h, nxt_in_w;
   logic             nxt_first, nxt_last;

   always_comb begin
      nxt_kw    = step_idx(mac.idx_kw, k_m,  1'b1);
      nxt_kh    = step_idx(mac.idx_kh, k_m,  c_kh);
      nxt_kd    = step_idx(mac.idx_kd, k_m,  c_kd);
      nxt_ic    = step_idx(mac.idx_ic, ic_m, c_ic);
      nxt_ow    = step_idx(mac.idx_ow, ow_m, c_ow);
      nxt_oh    = step_idx(mac.idx_oh, oh_m, c_oh);
      nxt_od    = step_idx(mac.idx_od, od_m, c_od);
      nxt_oc    = step_idx(mac.idx_oc, oc_m, c_oc);
      nxt_in_d  = {1'b0, nxt_od} + {1'b0, nxt_kd};
      nxt_in_h  = {1'b0, nxt_oh} + {1'b0, nxt_kh};
      nxt_in_w  = {1'b0, nxt_ow} + {1'b0, nxt_kw};
      nxt_first = (nxt_ic == '0) && (nxt_kd == '0) && (nxt_kh == '0) && (nxt_kw == '0);
      nxt_last  = (nxt_ic == ic_m) && (nxt_kd == k_m) && (nxt_kh == k_m) && (nxt_kw == k_m);
   end

   logic cfg_zero;
   logic cfg_single;

   assign cfg_zero   = (cfg_oc == '0) || (cfg_od == '0) || (cfg_oh == '0) ||
                       (cfg_ow == '0) || (cfg_ic == '0) || (cfg_k  == '0);
   assign cfg_single = (cfg_ic == ONE) && (cfg_k == ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         oc_r          <= '0;
         od_r          <= '0;
         oh_r          <= '0;
         ow_r          <= '0;
         ic_r          <= '0;
         k_r           <= '0;
         mac.mac_valid <= 1'b0;
         mac.idx_oc    <= '0;
         mac.idx_od    <= '0;
         mac.idx_oh    <= '0;
         mac.idx_ow    <= '0;
         mac.idx_ic    <= '0;
         mac.idx_kd    <= '0;
         mac.idx_kh    <= '0;
         mac.idx_kw    <= '0;
         mac.in_d      <= '0;
         mac.in_h      <= '0;
         mac.in_w      <= '0;
         mac.acc_first <= 1'b0;
         mac.acc_last  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  oc_r       <= cfg_oc;
                  od_r       <= cfg_od;
                  oh_r       <= cfg_oh;
                  ow_r       <= cfg_ow;
                  ic_r       <= cfg_ic;
                  k_r        <= cfg_k;
                  mac.idx_oc <= '0;
                  mac.idx_od <= '0;
                  mac.idx_oh <= '0;
                  mac.idx_ow <= '0;
                  mac.idx_ic <= '0;
                  mac.idx_kd <= '0;
                  mac.idx_kh <= '0;
                  mac.idx_kw <= '0;
                  mac.in_d   <= '0;
                  mac.in_h   <= '0;
                  mac.in_w   <= '0;
                  if (cfg_zero) begin
                     // Empty iteration space: report completion without issuing tuples.
                     state         <= ST_DONE;
                     done          <= 1'b1;
                     mac.acc_first <= 1'b0;
                     mac.acc_last  <= 1'b0;
                  end else begin
                     state         <= ST_RUN;
                     mac.mac_valid <= 1'b1;
                     busy          <= 1'b1;
                     mac.acc_first <= 1'b1;
                     mac.acc_last  <= cfg_single;
                  end
               end
            end

            ST_RUN: begin
               // mac_valid is constantly high in RUN, so ready alone marks a transfer.
               if (mac.mac_ready) begin
                  if (last_all) begin
                     state         <= ST_DONE;
                     mac.mac_valid <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     mac.acc_first <= 1'b0;
                     mac.acc_last  <= 1'b0;
                  end else begin
                     mac.idx_oc    <= nxt_oc;
                     mac.idx_od    <= nxt_od;
                     mac.idx_oh    <= nxt_oh;
                     mac.idx_ow    <= nxt_ow;
                     mac.idx_ic    <= nxt_ic;
                     mac.idx_kd    <= nxt_kd;
                     mac.idx_kh    <= nxt_kh;
                     mac.idx_kw    <= nxt_kw;
                     mac.in_d      <= nxt_in_d;
                     mac.in_h      <= nxt_in_h;
                     mac.in_w      <= nxt_in_w;
                     mac.acc_first <= nxt_first;
                     mac.acc_last  <= nxt_last;
                  end
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state         <= ST_IDLE;
               mac.mac_valid <= 1'b0;
               busy          <= 1'b0;
               done          <= 1'b0;
            end
         endcase
      end
   end

`ifdef CONV3D_SCHED_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state == ST_IDLE) && start) begin
         stall_cnt <= '0;
      end else if (mac.mac_valid && !mac.mac_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_conv3d_loop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv3d_loop_scheduler
// Scoreboard bench: every accepted pass pushes its full expected tuple
// sequence, generated by plain nested loops, and each presented beat is
// compared against the queue head (popped on transfer, peeked during stalls).
// Define CONV3D_SCHED_PERF_EN to also check stall_cnt.
// -----------------------------------------------------------------------------
module tb_conv3d_loop_scheduler;

   localparam int DIM_W = 8;
   localparam int CNT_W = 32;

   typedef struct packed {
      logic [DIM_W-1:0] oc, od, oh, ow, ic, kd, kh, kw;
      logic [DIM_W:0]   d, h, w;
      logic             first, last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [DIM_W-1:0] cfg_oc, cfg_od, cfg_oh, cfg_ow, cfg_ic, cfg_k;
   logic             busy;
   logic             done;
`ifdef CONV3D_SCHED_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   conv3d_loop_scheduler_if #(.DIM_W(DIM_W)) mac_if ();

   conv3d_loop_scheduler #(
      .DIM_W (DIM_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cfg_oc (cfg_oc),
      .cfg_od (cfg_od),
      .cfg_oh (cfg_oh),
      .cfg_ow (cfg_ow),
      .cfg_ic (cfg_ic),
      .cfg_k  (cfg_k),
      .mac    (mac_if),
      .busy   (busy),
      .done   (done)
`ifdef CONV3D_SCHED_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q[$];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic beat_t observe();
      beat_t b;
      b.oc = mac_if.idx_oc; b.od = mac_if.idx_od; b.oh = mac_if.idx_oh; b.ow = mac_if.idx_ow;
      b.ic = mac_if.idx_ic; b.kd = mac_if.idx_kd; b.kh = mac_if.idx_kh; b.kw = mac_if.idx_kw;
      b.d = mac_if.in_d; b.h = mac_if.in_h; b.w = mac_if.in_w;
      b.first = mac_if.acc_first; b.last = mac_if.acc_last;
      return b;
   endfunction

   function automatic logic [127:0] observe_all();
      return {mac_if.mac_valid, busy, done, observe()};
   endfunction

   task automatic push_expected(input int oc, od, oh, ow, ic, k);
      beat_t b;
      for (int a = 0; a < oc; a++)
         for (int bd = 0; bd < od; bd++)
            for (int bh = 0; bh < oh; bh++)
               for (int bw = 0; bw < ow; bw++)
                  for (int c = 0; c < ic; c++)
                     for (int zd = 0; zd < k; zd++)
                        for (int zh = 0; zh < k; zh++)
                           for (int zw = 0; zw < k; zw++) begin
                              b.oc = DIM_W'(a);  b.od = DIM_W'(bd); b.oh = DIM_W'(bh); b.ow = DIM_W'(bw);
                              b.ic = DIM_W'(c);  b.kd = DIM_W'(zd); b.kh = DIM_W'(zh); b.kw = DIM_W'(zw);
                              b.d = (DIM_W+1)'(bd + zd);
                              b.h = (DIM_W+1)'(bh + zh);
                              b.w = (DIM_W+1)'(bw + zw);
                              b.first = (c == 0) && (zd == 0) && (zh == 0) && (zw == 0);
                              b.last  = (c == ic-1) && (zd == k-1) && (zh == k-1) && (zw == k-1);
                              exp_q.push_back(b);
                           end
   endtask

   // Runs one pass. stall_at/stall_len: hold mac_ready low for stall_len cycles
   // while beat number stall_at is presented. abort_at: return as soon as beat
   // number abort_at is presented, leaving the pass in flight.
   task automatic run_pass(input int oc, od, oh, ow, ic, k,
                           input int stall_at, stall_len, abort_at);
      int    beats       = 0;
      int    last_xfer   = -1;
      int    stalls_left = stall_len;
      int    acc_last_n  = 0;
      int    max_in_w    = 0;
      int    total;
      bit    got_done    = 0;
      beat_t ob;
      total = oc * od * oh * ow * ic * k * k * k;

      @(negedge clk);
      cfg_oc = DIM_W'(oc); cfg_od = DIM_W'(od); cfg_oh = DIM_W'(oh);
      cfg_ow = DIM_W'(ow); cfg_ic = DIM_W'(ic); cfg_k  = DIM_W'(k);
      start  = 1'b1;
      exp_q.delete();
      if (total > 0)
         push_expected(oc, od, oh, ow, ic, k);
      @(negedge clk);
      // Changing cfg after acceptance must not disturb the pass.
      cfg_oc = DIM_W'($urandom_range(1, 4)); cfg_od = DIM_W'($urandom_range(1, 4));
      cfg_oh = DIM_W'($urandom_range(1, 4)); cfg_ow = DIM_W'($urandom_range(1, 4));
      cfg_ic = DIM_W'($urandom_range(1, 4)); cfg_k  = DIM_W'($urandom_range(1, 4));

      for (int cyc = 0; cyc < 4000; cyc++) begin
         start = (cyc == 2);
         if (stalls_left > 0 && beats == stall_at - 1) begin
            mac_if.mac_ready = 1'b0;
            stalls_left--;
         end else begin
            mac_if.mac_ready = 1'b1;
         end
         if (cyc == 0)
            check("valid_first_cycle", mac_if.mac_valid, total > 0);
         if (abort_at > 0 && beats == abort_at - 1 && mac_if.mac_valid) begin
            start = 1'b0;
            return;
         end
         if (done) begin
            check("done_latency", cyc - last_xfer, 1);
            check("busy_at_done", busy, 1'b0);
            check("valid_at_done", mac_if.mac_valid, 1'b0);
            got_done = 1;
            break;
         end
         if (mac_if.mac_valid) begin
            if (exp_q.size() == 0) begin
               check("no_extra_beat", mac_if.mac_valid, 1'b0);
               break;
            end
            ob = observe();
            check("busy_in_run", busy, 1'b1);
            check(mac_if.mac_ready ? "beat" : "stall_hold", ob, exp_q[0]);
            if (mac_if.mac_ready) begin
               if (ob.last) acc_last_n++;
               if (int'(ob.w) > max_in_w) max_in_w = int'(ob.w);
               void'(exp_q.pop_front());
               beats++;
               last_xfer = cyc;
            end
         end
         @(negedge clk);
      end

      check("got_done", got_done, 1'b1);
      check("beat_count", beats, total);
      check("acc_last_count", acc_last_n, oc * od * oh * ow * ((total > 0) ? 1 : 0));
      if (total > 0)
         check("max_in_w", max_in_w, ow + k - 2);
`ifdef CONV3D_SCHED_PERF_EN
      check("stall_cnt", stall_cnt, stall_len);
`endif
      // A start during DONE must be ignored, and done must last one cycle.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", done, 1'b0);
      check("idle_after_done", {mac_if.mac_valid, busy}, 2'b00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mac_if.mac_ready = 1'b0;
      cfg_oc = '0; cfg_od = '0; cfg_oh = '0; cfg_ow = '0; cfg_ic = '0; cfg_k = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", observe_all(), '0);
`ifdef CONV3D_SCHED_PERF_EN
      check("reset_stall_cnt", stall_cnt, 0);
`endif
      rst = 1'b0;

      run_pass(1, 1, 1, 1, 1, 1, 0, 0, 0);   // single beat, first=last=1
      run_pass(1, 1, 1, 1, 1, 2, 0, 0, 0);   // 8 kernel beats
      run_pass(2, 1, 1, 3, 2, 2, 5, 3, 0);   // 96 beats with a 3-cycle stall at beat 5
      run_pass(1, 2, 3, 2, 3, 1, 0, 0, 0);   // exercises od/oh carries, k=1
      run_pass(1, 1, 1, 1, 0, 1, 0, 0, 0);   // zero in-channels: no beats
      run_pass(2, 1, 1, 3, 2, 2, 0, 0, 10);  // abandoned at beat 10

      // Reset mid-pass, with start asserted in the same cycle.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check("midpass_reset", observe_all(), '0);
`ifdef CONV3D_SCHED_PERF_EN
      check("midpass_stall_cnt", stall_cnt, 0);
`endif
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("start_with_rst_ignored", {mac_if.mac_valid, busy, done}, 3'b000);

      run_pass(2, 1, 1, 3, 2, 2, 0, 0, 0);   // restarts from index zero

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
